alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU.
// Grants one op, drives the ALU for one cycle, and holds the response until it is taken.
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [17:0] req0_cntl,
  input  logic [17:0] req1_cntl,
  input  logic [31:0] req0_opnd0,
  input  logic [31:0] req0_opnd1,
  input  logic [31:0] req1_opnd0,
  input  logic [31:0] req1_opnd1,
  input  logic [6:0]  flags_in,
  output logic [17:0] alu_cntl,
  output logic [31:0] alu_opnd0,
  output logic [31:0] alu_opnd1,
  output logic [6:0]  alu_status_in,
  input  logic [31:0] alu_result,
  input  logic [6:0]  alu_status_out,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_result,
  output logic [6:0]  rsp_status,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [17:0] cntl;
    logic [31:0] opnd0;
    logic [31:0] opnd1;
  } op_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_gnt;
  logic        r_last;
  op_t         r_op;
  op_t         w_req_op;
  logic [31:0] r_result;
  logic [6:0]  r_status;
  logic        w_any;
  logic        w_gnt1;
  logic        w_take;
  logic        w_rsp_done;

  // Pick the winner among the currently valid requesters.
  always_comb begin
    w_any  = req0_valid | req1_valid;
    w_gnt1 = 1'b0;
    if (FIXED_PRIO) begin
      w_gnt1 = !req0_valid;
    end else if (req0_valid && req1_valid) begin
      w_gnt1 = !r_last;
    end else begin
      w_gnt1 = !req0_valid;
    end
  end

  // Handshake and operand selection for the granted requester.
  always_comb begin
    w_take     = rst_n & w_any & (r_state == S_IDLE);
    req0_ready = w_take & !w_gnt1;
    req1_ready = w_take & w_gnt1;
    w_req_op   = '0;
    if (w_gnt1) begin
      w_req_op.cntl  = req1_cntl;
      w_req_op.opnd0 = req1_opnd0;
      w_req_op.opnd1 = req1_opnd1;
    end else begin
      w_req_op.cntl  = req0_cntl;
      w_req_op.opnd0 = req0_opnd0;
      w_req_op.opnd1 = req0_opnd1;
    end
  end

  // Only the granted requester may retire the response.
  always_comb begin
    w_rsp_done = r_gnt ? rsp1_ready : rsp0_ready;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_take) w_next = S_EXEC;
      S_EXEC: w_next = S_RESP;
      S_RESP: if (w_rsp_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // ALU drive and response outputs; ALU sees zeros except in EXEC.
  always_comb begin
    alu_cntl      = '0;
    alu_opnd0     = '0;
    alu_opnd1     = '0;
    alu_status_in = '0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    busy          = (r_state != S_IDLE);
    rsp_result    = r_result;
    rsp_status    = r_status;
    if (r_state == S_EXEC) begin
      alu_cntl      = r_op.cntl;
      alu_opnd0     = r_op.opnd0;
      alu_opnd1     = r_op.opnd1;
      alu_status_in = flags_in;
    end
    if (r_state == S_RESP) begin
      rsp0_valid = !r_gnt;
      rsp1_valid = r_gnt;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the granted op and remember who won.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_gnt  <= 1'b0;
      r_last <= 1'b1;
    end else if (w_take) begin
      r_op   <= w_req_op;
      r_gnt  <= w_gnt1;
      r_last <= w_gnt1;
    end
  end

  // Latch the ALU outputs at the end of the execute cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_status <= '0;
    end else if (r_state == S_EXEC) begin
      r_result <= alu_result;
      r_status <= alu_status_out;
    end
  end

endmodule
